// File: rtl/orient_pkg.sv
// Shared definitions for the keypoint orientation normaliser: FSM states and
// widths derived from the moment/fraction parameters (ORIENT_NORM_ROUND_EN aware).
package orient_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQRT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int rad_w(input int mw);
    return 2 * mw;
  endfunction

  function automatic int quo_w(input int frac);
    return frac + 1;
  endfunction

  // One extra quotient bit is produced when rounding, to supply the half bit.
  function automatic int div_iter(input int frac);
`ifdef ORIENT_NORM_ROUND_EN
    return frac + 2;
`else
    return frac + 1;
`endif
  endfunction

endpackage

// File: rtl/orient_sdiv.sv
// Serial restoring divider, one quotient bit per cycle. Assumes the quotient
// fits in ITER bits, i.e. (dividend >> ITER) < divisor.
module orient_sdiv #(
  parameter int WD   = 21,
  parameter int ITER = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WD+ITER-2:0]   dividend,
  input  logic [WD-1:0]        divisor,
  output logic                 busy,
  output logic [ITER-1:0]      quotient
);

  localparam int CW = $clog2(ITER + 1);

  logic [WD-1:0]   rem_r;
  logic [ITER-1:0] sh_r;
  logic [WD-1:0]   dvs_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic [WD:0]     trial_s;
  logic [WD:0]     diff_s;
  logic            ge_s;

  assign busy     = busy_r;
  assign quotient = sh_r;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial_s = {rem_r, sh_r[ITER-1]};
    diff_s  = trial_s - {1'b0, dvs_r};
    ge_s    = (trial_s >= {1'b0, dvs_r});
  end

  // Load on start, then shift one quotient bit into sh_r per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= {WD{1'b0}};
      sh_r   <= {ITER{1'b0}};
      dvs_r  <= {WD{1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= {1'b0, dividend[WD+ITER-2:ITER]};
      sh_r   <= dividend[ITER-1:0];
      dvs_r  <= divisor;
      cnt_r  <= CW'(ITER);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= ge_s ? WD'(diff_s) : WD'(trial_s);
      sh_r   <= {sh_r[ITER-2:0], ge_s};
      cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      busy_r <= (cnt_r != {{(CW-1){1'b0}}, 1'b1});
    end
  end

endmodule

// File: rtl/orient_norm.sv
// Normalises a moment vector (m10, m01) to (cos, sin) in Q FRAC via a serial
// isqrt and two serial dividers. Define ORIENT_NORM_ROUND_EN for rounded quotients.
module orient_norm
  import orient_pkg::*;
#(
  parameter int MW   = 21,
  parameter int FRAC = 12,
  parameter int AW   = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [MW-1:0]   m10,
  input  logic signed [MW-1:0]   m01,
  input  logic [AW-1:0]          addr_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [FRAC+1:0] cos,
  output logic signed [FRAC+1:0] sin,
  output logic [AW-1:0]          addr_out,
  output logic                   zero
);

  localparam int RW   = rad_w(MW);
  localparam int QW   = quo_w(FRAC);
  localparam int ITER = div_iter(FRAC);
  localparam int DW   = MW + ITER - 1;
  localparam int CW   = $clog2(MW + 1);
  localparam int OW   = FRAC + 2;
  localparam logic [ITER:0] SAT     = {{(ITER-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [OW-1:0] UNIT_OW = {1'b0, 1'b1, {FRAC{1'b0}}};

  state_t          state_r;
  logic            in_ready_r;
  logic [RW-1:0]   rad_r;
  logic [MW+1:0]   rem_r;
  logic [MW-1:0]   root_r;
  logic [CW-1:0]   cnt_r;
  logic [MW-1:0]   abs10_r, abs01_r;
  logic            neg10_r, neg01_r, zin_r;
  logic [AW-1:0]   addr_r;
  logic            out_valid_r, zero_r;
  logic [OW-1:0]   cos_r, sin_r;
  logic [AW-1:0]   addr_out_r;

  logic [MW-1:0]   a10_s, a01_s;
  logic [RW-1:0]   sq_s;
  logic [MW+3:0]   rem_sh_s, trial_s, diff_s;
  logic [MW+1:0]   rem_nx_s;
  logic [MW-1:0]   root_nx_s;
  logic            last_sqrt_s;
  logic            busy_c_s, busy_s_s;
  logic [ITER-1:0] q_c_s, q_s_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign cos       = cos_r;
  assign sin       = sin_r;
  assign addr_out  = addr_out_r;
  assign zero      = zero_r;

  function automatic logic [MW-1:0] abs_mag(input logic [MW-1:0] v);
    return v[MW-1] ? (~v + {{(MW-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Quotient magnitude, never above 1.0 (2^FRAC).
  function automatic logic [QW-1:0] fin_mag(input logic [ITER-1:0] q);
    logic [ITER:0] t;
`ifdef ORIENT_NORM_ROUND_EN
    t = ({1'b0, q} + {{ITER{1'b0}}, 1'b1}) >> 1;
`else
    t = {1'b0, q};
`endif
    if (t > SAT) begin
      return QW'(SAT);
    end else begin
      return QW'(t);
    end
  endfunction

  function automatic logic [OW-1:0] signed_out(input logic neg, input logic [QW-1:0] m);
    logic [OW-1:0] v;
    v = {1'b0, m};
    return neg ? (~v + {{(OW-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Radicand from the presented pair, and one restoring isqrt step.
  always_comb begin
    a10_s    = abs_mag(m10);
    a01_s    = abs_mag(m01);
    sq_s     = {{MW{1'b0}}, a10_s} * {{MW{1'b0}}, a10_s}
             + {{MW{1'b0}}, a01_s} * {{MW{1'b0}}, a01_s};
    rem_sh_s = {rem_r, rad_r[RW-1 -: 2]};
    trial_s  = {2'b00, root_r, 2'b01};
    diff_s   = rem_sh_s - trial_s;
    if (rem_sh_s >= trial_s) begin
      rem_nx_s  = (MW+2)'(diff_s);
      root_nx_s = MW'({root_r, 1'b1});
    end else begin
      rem_nx_s  = (MW+2)'(rem_sh_s);
      root_nx_s = MW'({root_r, 1'b0});
    end
    last_sqrt_s = (state_r == SQRT) && (cnt_r == CW'(MW - 1));
  end

  // Dividers launch on the final isqrt step, fed its combinational root.
  orient_sdiv #(.WD(MW), .ITER(ITER)) u_div_cos (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (last_sqrt_s),
    .dividend ({abs10_r, {(ITER-1){1'b0}}}),
    .divisor  (root_nx_s),
    .busy     (busy_c_s),
    .quotient (q_c_s)
  );

  orient_sdiv #(.WD(MW), .ITER(ITER)) u_div_sin (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (last_sqrt_s),
    .dividend ({abs01_r, {(ITER-1){1'b0}}}),
    .divisor  (root_nx_s),
    .busy     (busy_s_s),
    .quotient (q_s_s)
  );

  // Control FSM, isqrt datapath and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      rad_r       <= {RW{1'b0}};
      rem_r       <= {(MW+2){1'b0}};
      root_r      <= {MW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      abs10_r     <= {MW{1'b0}};
      abs01_r     <= {MW{1'b0}};
      neg10_r     <= 1'b0;
      neg01_r     <= 1'b0;
      zin_r       <= 1'b0;
      addr_r      <= {AW{1'b0}};
      out_valid_r <= 1'b0;
      cos_r       <= {OW{1'b0}};
      sin_r       <= {OW{1'b0}};
      addr_out_r  <= {AW{1'b0}};
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            abs10_r    <= a10_s;
            abs01_r    <= a01_s;
            neg10_r    <= m10[MW-1];
            neg01_r    <= m01[MW-1];
            zin_r      <= (m10 == {MW{1'b0}}) && (m01 == {MW{1'b0}});
            addr_r     <= addr_in;
            rad_r      <= sq_s;
            rem_r      <= {(MW+2){1'b0}};
            root_r     <= {MW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= SQRT;
          end
        end
        SQRT: begin
          rad_r  <= {rad_r[RW-3:0], 2'b00};
          rem_r  <= rem_nx_s;
          root_r <= root_nx_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_sqrt_s) begin
            state_r <= DIV;
          end
        end
        DIV: begin
          if (!busy_c_s && !busy_s_s) begin
            cos_r       <= zin_r ? UNIT_OW : signed_out(neg10_r, fin_mag(q_c_s));
            sin_r       <= zin_r ? {OW{1'b0}} : signed_out(neg01_r, fin_mag(q_s_s));
            addr_out_r  <= addr_r;
            zero_r      <= zin_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orient_norm.sv
// Self-checking bench for orient_norm: directed corner cases, random pairs,
// output stall with a held request, and mid-operation reset.
module tb_orient_norm;

  localparam int MW   = 21;
  localparam int FRAC = 12;
  localparam int AW   = 14;
`ifdef ORIENT_NORM_ROUND_EN
  localparam int LAT = MW + FRAC + 3;
`else
  localparam int LAT = MW + FRAC + 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [MW-1:0]   m10, m01;
  logic [AW-1:0]          addr_in;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [FRAC+1:0] cos, sin;
  logic [AW-1:0]          addr_out;
  logic                   zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  orient_norm #(.MW(MW), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .m10(m10), .m01(m01), .addr_in(addr_in), .out_valid(out_valid),
    .out_ready(out_ready), .cos(cos), .sin(sin), .addr_out(addr_out), .zero(zero)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = longint'(1) << 22;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint qmag(input longint x, input longint mag);
    longint q;
    longint one;
    one = longint'(1) << FRAC;
`ifdef ORIENT_NORM_ROUND_EN
    q = (2 * x * one + mag) / (2 * mag);
`else
    q = (x * one) / mag;
`endif
    return (q > one) ? one : q;
  endfunction

  task automatic model(input longint a, input longint b,
                       output longint c, output longint s, output longint z);
    longint mag;
    mag = isqrt(a * a + b * b);
    if (mag == 0) begin
      c = longint'(1) << FRAC;
      s = 0;
      z = 1;
    end else begin
      c = (a < 0) ? -qmag(-a, mag) : qmag(a, mag);
      s = (b < 0) ? -qmag(-b, mag) : qmag(b, mag);
      z = 0;
    end
  endtask

  // Present a pair and return just after its acceptance edge.
  task automatic send(input longint a, input longint b, input logic [AW-1:0] ad);
    int n;
    logic [63:0] av, bv;
    av = a;
    bv = b;
    m10 = av[MW-1:0];
    m01 = bv[MW-1:0];
    addr_in = ad;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input longint a, input longint b, input logic [AW-1:0] ad, input string tag);
    longint c, s, z;
    int lat;
    model(a, b, c, s, z);
    send(a, b, ad);
    wait_out(lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_cos"}, cos, c);
    chk({tag, "_sin"}, sin, s);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_addr"}, addr_out, ad);
    consume();
    chk({tag, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    longint ca, sa, za, cb, sb, zb;
    longint ra, rb;
    int lat, hits;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    m10 = '0;
    m01 = '0;
    addr_in = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cos", cos, 0);
    chk("rst_sin", sin, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(3, 4, 14'h0001, "p3_4");
    run(-3, 4, 14'h1234, "n3_4");
    run(0, 0, 14'h3fff, "zero");
    run(-(longint'(1) << 20), 0, 14'h0100, "negmax");
    run(1, 1, 14'h0002, "one_one");
    run(0, -7, 14'h0003, "axis_y");
    run((longint'(1) << 20) - 1, -(longint'(1) << 20), 14'h2aaa, "extreme");

    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        ra = longint'(int'($urandom) >>> 11);
        rb = longint'(int'($urandom) >>> 11);
      end else begin
        ra = longint'(int'($urandom_range(0, 64))) - 32;
        rb = longint'(int'($urandom_range(0, 64))) - 32;
      end
      run(ra, rb, AW'($urandom), $sformatf("rand%0d", i));
    end

    // Output stall with a second request held throughout.
    model(7, -24, ca, sa, za);
    model(5, 12, cb, sb, zb);
    send(7, -24, 14'h0a0a);
    wait_out(lat);
    chk("stall_a_lat", lat, LAT);
    m10 = 21'sd5;
    m01 = 21'sd12;
    addr_in = 14'h0b0b;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_cos_%0d", i), cos, ca);
      chk($sformatf("stall_sin_%0d", i), sin, sa);
      chk($sformatf("stall_hs_%0d", i), {out_valid, in_ready}, 2'b10);
    end
    chk("stall_addr", addr_out, 14'h0a0a);
    consume();
    chk("stall_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stall_b_taken", in_ready, 0);
    wait_out(lat);
    chk("stall_b_lat", lat, LAT);
    chk("stall_b_cos", cos, cb);
    chk("stall_b_sin", sin, sb);
    chk("stall_b_addr", addr_out, 14'h0b0b);
    consume();
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    chk("stall_b_once", hits, 0);

    // Reset pulsed during the square-root phase.
    send(100, -200, 14'h0777);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cos", cos, 0);
    chk("midrst_sin", sin, 0);
    chk("midrst_addr", addr_out, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    chk("midrst_no_stale", hits, 0);
    run(100, -200, 14'h0777, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/orient_norm.md
ORIENT_NORM -- requirements
Module: orient_norm

Interface
REQ-001 Parameter MW, default 21, signed moment width.
REQ-002 Parameter FRAC, default 12, fraction bits of the sin/cos outputs.
REQ-003 Parameter AW, default 14, keypoint address sideband width.
REQ-004 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: a moment pair is presented.
REQ-007 Port in_ready, output, 1: the block accepts the pair this cycle.
REQ-008 Port m10, input, MW: signed x-moment.
REQ-009 Port m01, input, MW: signed y-moment.
REQ-010 Port addr_in, input, AW: keypoint address, carried unchanged to addr_out.
REQ-011 Port out_valid, output, 1: the result is valid.
REQ-012 Port out_ready, input, 1: the consumer takes the result.
REQ-013 Port cos, output, FRAC+2: signed two's complement, m10/|m|, scaled by 2^FRAC.
REQ-014 Port sin, output, FRAC+2: signed two's complement, m01/|m|, scaled by 2^FRAC.
REQ-015 Port addr_out, output, AW: address captured with the accepted pair.
REQ-016 Port zero, output, 1: the accepted pair had m10=m01=0.

Function
REQ-017 The FSM SHALL use states IDLE, SQRT, DIV, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 A pair SHALL be accepted on in_valid&in_ready, capturing m10, m01 and addr_in, and the FSM SHALL move to SQRT.
REQ-020 SQRT SHALL compute mag = floor(sqrt(m10^2+m01^2)) with an unsigned 2*MW-bit radicand, one bit-serial iteration per cycle, MW cycles, then move to DIV.
REQ-021 DIV SHALL compute |m10|*2^FRAC/mag and |m01|*2^FRAC/mag concurrently by restoring division, one quotient bit per cycle, FRAC+1 cycles, then move to DONE.
REQ-022 Each quotient magnitude SHALL be at most 2^FRAC; the sign SHALL be reapplied from the input sign, giving a two's complement result.
REQ-023 If mag=0, the result SHALL be cos=2^FRAC, sin=0 and zero=1, with the same latency.
REQ-024 In DONE, out_valid SHALL be 1 and cos, sin, addr_out and zero SHALL hold stable until out_ready=1.
REQ-025 On out_valid&out_ready, the FSM SHALL return to IDLE.
REQ-026 Latency SHALL be MW+FRAC+2 cycles from the acceptance edge to out_valid=1 (35 cycles at the defaults).
REQ-027 in_valid SHALL be ignored outside IDLE; a pending pair SHALL not be lost, because it remains presented until in_ready.
REQ-028 Outputs SHALL change only on entry to DONE or on reset.

Reset
REQ-029 rst_n=0 SHALL force, immediately, state IDLE, out_valid=0, cos=0, sin=0, addr_out=0, zero=0 and all datapath registers to 0.
REQ-030 Reset mid-operation SHALL abort the calculation with no output; in_ready SHALL be 1 on the first clock edge after release.

Configuration
REQ-031 With macro ORIENT_NORM_ROUND_EN defined, DIV SHALL run FRAC+2 cycles, round half-up on the magnitude, and saturate to 2^FRAC; latency SHALL become MW+FRAC+3 cycles.
REQ-032 Without ORIENT_NORM_ROUND_EN, quotients SHALL truncate toward zero, and the latency of REQ-026 SHALL apply.

Structure
REQ-033 Package orient_pkg SHALL hold the FSM state enum and constants derived from the parameters: radicand width 2*MW, quotient width FRAC+1, and the DIV iteration count.
REQ-034 A sub-module orient_sdiv (serial restoring divider: start, dividend, divisor, busy, quotient) SHALL be instantiated twice; the isqrt SHALL remain inline.

Verification
REQ-035 m10=3, m01=4 (defaults, truncating) -> out_valid after 35 cycles, cos=2457, sin=3276, zero=0; with ORIENT_NORM_ROUND_EN -> cos=2458, sin=3277 after 36 cycles.
REQ-036 m10=-3, m01=4, addr_in=0x1234 -> cos=-2457, sin=3276, addr_out=0x1234.
REQ-037 m10=0, m01=0 -> cos=4096, sin=0, zero=1, same latency.
REQ-038 m10=-2^20, m01=0 -> cos=-4096, sin=0; m10=1, m01=1 -> cos=4096, sin=4096 (floor isqrt saturation case).
REQ-039 out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; a second in_valid held through the stall -> accepted exactly once, on the first IDLE cycle.
REQ-040 rst_n pulsed low during SQRT -> out_valid=0 and all outputs 0 immediately; no stale result appears; the next pair completes with normal latency.
